// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the K=3, 4-state Viterbi decoder datapath.
package viterbi_pkg;

    localparam int NUM_STATES = 4;
    localparam int STATE_W    = 2;

    typedef logic [STATE_W-1:0]    state_t;
    typedef logic [NUM_STATES-1:0] sel_vec_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        TRACE = 2'd1,
        DRAIN = 2'd2
    } tbu_state_e;

    // With next = {in_bit, cur[1]}, the survivor into s came from {s[0], sel}.
    function automatic state_t pred_state(state_t s, logic sel);
        return {s[0], sel};
    endfunction

endpackage

// File: rtl/tbu_frame_if.sv
// Step-in / decoded-bit-out bus of the traceback unit.
// The master side feeds ACS selections and consumes decoded bits.
interface tbu_frame_if;
    import viterbi_pkg::*;

    logic     sel_valid_i;
    sel_vec_t sel_i;
    state_t   best_state_i;
    logic     ready_o;
    logic     dec_valid_o;
    logic     dec_bit_o;
    logic     dec_last_o;

    modport master (
        output sel_valid_i, sel_i, best_state_i,
        input  ready_o, dec_valid_o, dec_bit_o, dec_last_o
    );

    modport slave (
        input  sel_valid_i, sel_i, best_state_i,
        output ready_o, dec_valid_o, dec_bit_o, dec_last_o
    );

endinterface

// File: rtl/survivor_mem.sv
// Survivor memory: one 4-bit ACS selection vector per trellis step of a frame.
// Synchronous write, combinational read so traceback can advance every cycle.
module survivor_mem
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = 16,
    parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  sel_vec_t          wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output sel_vec_t          rd_data_o
);

    sel_vec_t mem_q [FRAME_LEN];

    // Store the selection vector of each accepted step; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/tbu_frame.sv
// Frame-based traceback unit: collects FRAME_LEN steps of ACS selections,
// traces back from the best end state, then emits decoded bits oldest first.
module tbu_frame
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = 16
) (
    input logic        clk,
    input logic        rst_n,
    tbu_frame_if.slave bus
);

    localparam int                ADDR_W   = $clog2(FRAME_LEN);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    tbu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] tcnt_q, tcnt_d;
    logic [ADDR_W-1:0] ocnt_q, ocnt_d;
    state_t            cur_q, cur_d;
    logic              dec_valid_q, dec_valid_d;
    logic              dec_bit_q, dec_bit_d;
    logic              dec_last_q, dec_last_d;
    logic [FRAME_LEN-1:0] dbuf_q;

    logic     ready;
    logic     accept;
    sel_vec_t surv_rd;
    logic     surv_bit;

    assign ready    = (state_q == FILL);
    assign accept   = bus.sel_valid_i && ready;
    assign surv_bit = surv_rd[cur_q];

    assign bus.ready_o     = ready;
    assign bus.dec_valid_o = dec_valid_q;
    assign bus.dec_bit_o   = dec_bit_q;
    assign bus.dec_last_o  = dec_last_q;

    survivor_mem #(
        .FRAME_LEN (FRAME_LEN),
        .ADDR_W    (ADDR_W)
    ) u_survivor_mem (
        .clk       (clk),
        .wr_en_i   (accept),
        .wr_addr_i (wcnt_q),
        .wr_data_i (bus.sel_i),
        .rd_addr_i (tcnt_q),
        .rd_data_o (surv_rd)
    );

    // Next-state logic for fill, traceback and drain phases.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        tcnt_d      = tcnt_q;
        ocnt_d      = ocnt_q;
        cur_d       = cur_q;
        dec_valid_d = dec_valid_q;
        dec_bit_d   = dec_bit_q;
        dec_last_d  = dec_last_q;

        case (state_q)
            FILL: begin
                if (accept) begin
                    wcnt_d = wcnt_q + ONE;
                    if (wcnt_q == LAST_IDX) begin
                        cur_d   = bus.best_state_i;
                        tcnt_d  = LAST_IDX;
                        state_d = TRACE;
                    end
                end
            end
            TRACE: begin
                cur_d  = pred_state(cur_q, surv_bit);
                tcnt_d = tcnt_q - ONE;
                if (tcnt_q == '0) begin
                    ocnt_d  = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (dec_last_q) begin
                    dec_valid_d = 1'b0;
                    dec_bit_d   = 1'b0;
                    dec_last_d  = 1'b0;
                    state_d     = FILL;
                end else begin
                    dec_valid_d = 1'b1;
                    dec_bit_d   = dbuf_q[ocnt_q];
                    dec_last_d  = (ocnt_q == LAST_IDX);
                    ocnt_d      = ocnt_q + ONE;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Control state and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            wcnt_q      <= '0;
            tcnt_q      <= '0;
            ocnt_q      <= '0;
            cur_q       <= '0;
            dec_valid_q <= 1'b0;
            dec_bit_q   <= 1'b0;
            dec_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            tcnt_q      <= tcnt_d;
            ocnt_q      <= ocnt_d;
            cur_q       <= cur_d;
            dec_valid_q <= dec_valid_d;
            dec_bit_q   <= dec_bit_d;
            dec_last_q  <= dec_last_d;
        end
    end

    // Traceback visits steps newest first, so bits land in their chronological slot.
    always_ff @(posedge clk) begin
        if (state_q == TRACE) begin
            dbuf_q[tcnt_q] <= cur_q[1];
        end
    end

endmodule

// File: tb/tb_tbu_frame.sv
// Randomized self-checking bench for tbu_frame with FRAME_LEN=8.
// Expected bits come from walking the survivor path of each frame backwards.
module tb_tbu_frame;
    import viterbi_pkg::*;

    localparam int N = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    tbu_frame_if bus();

    tbu_frame #(.FRAME_LEN(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks     = 0;
    int failures   = 0;
    int violations = 0;

    sel_vec_t frameSel [N];
    state_t   frameBest;
    logic     expBits  [N];

    // Free-running clock.
    always #5 clk = ~clk;

    // Protocol monitor: a step offered while the unit is busy gets dropped.
    always @(posedge clk) begin
        if (rst_n && bus.sel_valid_i && !bus.ready_o) begin
            violations++;
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation still running, expected completion");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Decoded bit k is the high bit of the survivor-path state after step k.
    function automatic void modelDecode();
        state_t s;
        s = frameBest;
        for (int k = N - 1; k >= 0; k--) begin
            expBits[k] = s[1];
            s = {s[0], frameSel[k][s]};
        end
    endfunction

    task automatic setFrame(input sel_vec_t pattern, input state_t best);
        for (int i = 0; i < N; i++) frameSel[i] = pattern;
        frameBest = best;
    endtask

    task automatic setRandomFrame();
        for (int i = 0; i < N; i++) frameSel[i] = sel_vec_t'($urandom_range(15, 0));
        frameBest = state_t'($urandom_range(3, 0));
    endtask

    task automatic applyStimulus(input bit holdValid);
        for (int i = 0; i < N; i++) begin
            bus.sel_valid_i  = 1'b1;
            bus.sel_i        = frameSel[i];
            bus.best_state_i = (i == N - 1) ? frameBest : state_t'($urandom_range(3, 0));
            if (i == 0) checkOutput("ready_at_frame_start", 32'(bus.ready_o), 32'd1);
            @(posedge clk);
            #1;
        end
        bus.sel_valid_i = holdValid;
        modelDecode();
    endtask

    task automatic checkFrame(input bit holdValid, input string name);
        int   lastCount;
        int   validCount;
        logic expValid;
        lastCount  = 0;
        validCount = 0;
        for (int c = 0; c <= 2 * N + 1; c++) begin
            if (holdValid) begin
                bus.sel_i        = sel_vec_t'($urandom_range(15, 0));
                bus.best_state_i = state_t'($urandom_range(3, 0));
            end
            @(negedge clk);
            expValid = (c >= N + 1) && (c <= 2 * N);
            checkOutput($sformatf("%s_ready_T+%0d", name, c), 32'(bus.ready_o), 32'(c == 2 * N + 1));
            checkOutput($sformatf("%s_valid_T+%0d", name, c), 32'(bus.dec_valid_o), 32'(expValid));
            if (expValid) begin
                checkOutput($sformatf("%s_bit%0d", name, c - N - 1), 32'(bus.dec_bit_o), 32'(expBits[c - N - 1]));
                checkOutput($sformatf("%s_last_T+%0d", name, c), 32'(bus.dec_last_o), 32'(c == 2 * N));
            end
            if (bus.dec_valid_o) validCount++;
            if (bus.dec_last_o) lastCount++;
        end
        bus.sel_valid_i = 1'b0;
        checkOutput($sformatf("%s_bit_count", name), 32'(validCount), 32'(N));
        checkOutput($sformatf("%s_last_count", name), 32'(lastCount), 32'd1);
    endtask

    task automatic runFrame(input bit holdValid, input string name);
        applyStimulus(holdValid);
        checkFrame(holdValid, name);
    endtask

    // Main test sequence.
    initial begin
        bus.sel_valid_i  = 1'b0;
        bus.sel_i        = '0;
        bus.best_state_i = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", 32'(bus.ready_o), 32'd1);
        checkOutput("reset_valid", 32'(bus.dec_valid_o), 32'd0);
        checkOutput("reset_bit", 32'(bus.dec_bit_o), 32'd0);
        checkOutput("reset_last", 32'(bus.dec_last_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] all-zero frame, best state 0");
        setFrame(4'b0000, 2'b00);
        runFrame(1'b0, "zeros");

        $display("[TB] all-one frame, best state 3");
        setFrame(4'b1111, 2'b11);
        runFrame(1'b0, "ones");

        $display("[TB] all-zero selections, best state 2");
        setFrame(4'b0000, 2'b10);
        runFrame(1'b0, "best2");
        checkOutput("best2_final_bit_model", 32'(expBits[N - 1]), 32'd1);

        $display("[TB] steps offered while busy");
        setRandomFrame();
        violations = 0;
        runFrame(1'b1, "busy_hold");
        checkOutput("violation_flagged", 32'(violations > 0), 32'd1);
        $display("[TB] protocol violations flagged: %0d", violations);
        runFrame(1'b0, "busy_repeat");

        $display("[TB] reset in the middle of traceback");
        setFrame(4'b0101, 2'b01);
        applyStimulus(1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_ready", 32'(bus.ready_o), 32'd1);
        checkOutput("midreset_valid", 32'(bus.dec_valid_o), 32'd0);
        checkOutput("midreset_bit", 32'(bus.dec_bit_o), 32'd0);
        checkOutput("midreset_last", 32'(bus.dec_last_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2 * N + 2; c++) begin
            @(negedge clk);
            checkOutput($sformatf("midreset_idle_valid%0d", c), 32'(bus.dec_valid_o), 32'd0);
            checkOutput($sformatf("midreset_idle_ready%0d", c), 32'(bus.ready_o), 32'd1);
        end
        setFrame(4'b0000, 2'b00);
        runFrame(1'b0, "after_reset");

        $display("[TB] back-to-back frames");
        setFrame(4'b0000, 2'b00);
        runFrame(1'b0, "b2b_zeros");
        setFrame(4'b1111, 2'b11);
        runFrame(1'b0, "b2b_ones");

        $display("[TB] random frames");
        for (int f = 0; f < 8; f++) begin
            setRandomFrame();
            runFrame(1'b0, $sformatf("rand%0d", f));
            if (f % 2 == 1) begin
                repeat ($urandom_range(3, 0)) @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
